rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Round-robin arbiter that shares the 4-input multiplexer datapath among four requesters. It drives the mux select (`sel`) and a one-hot grant vector, which is the 2-to-4 decode of `sel`, back to the requesters. A configurable hold limit stops any single requester from monopolising the shared path while others wait. The arbiter sits between the requester ports and the `mux4in` / `decoder4out` pair.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another request is pending; legal range 0..255; 0 = no limit.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in 4: request per requester; owner keeps its bit high for as long as it uses the path.
- `gnt` out 4: one-hot grant, registered; all zero when nobody owns the path.
- `sel` out 2: mux select, registered; index of current or most recent owner.
- `busy` out 1: high exactly while `gnt != 0`.
- `preempt` out 1: one-cycle pulse, high in the gap cycle that follows a hold-limit revocation.

## Operation
- Registered state:
  - FSM state: IDLE, GRANT, GAP.
  - `last[1:0]`: most recent owner.
  - `hold_cnt[7:0]`: grant-length counter.
- Arbitration (combinational, evaluated only in IDLE and GAP):
  - Scan `req` circularly starting at `last+1`.
  - The first set bit wins, giving index `w`.
- IDLE:
  - Outputs: `gnt=0`, `busy=0`.
  - If any `req` bit is set, go to GRANT with `gnt=1<<w`, `sel=w`, `last=w`, `hold_cnt=1`.
  - Otherwise stay in IDLE.
- GRANT, when `req[sel]=0`:
  - Go to GAP, `preempt=0`.
- GRANT, when `MAX_HOLD!=0`, `hold_cnt==MAX_HOLD` and any other `req` bit is set:
  - Go to GAP, `preempt=1`.
- GRANT, otherwise:
  - Stay in GRANT.
  - `hold_cnt` increments, saturating at 255.
- GAP:
  - Dead cycle: `gnt=0`, `busy=0`; `sel` holds the previous owner.
  - Arbitration uses the same rules as IDLE and can go directly to GRANT.
  - With no requests, go to IDLE.
  - `preempt` clears after one cycle.
- Preempted owner:
  - May keep `req` high.
  - Because `last` equals its index, it has lowest priority in the next arbitration.
  - If it is the only requester left, it is re-granted after the gap.
- No contention: a sole requester keeps the grant indefinitely, whatever `MAX_HOLD` is.
- Invariants:
  - `gnt` is one-hot or zero.
  - When `busy=1`, `gnt == 1<<sel`.
  - Never two grants on consecutive cycles without an intervening GAP cycle, so the mux never switches owners in a single edge.

## Timing
- Reset (synchronous, sampled on a `clk` edge with `reset=1`):
  - `gnt=0`, `sel=0`, `busy=0`, `preempt=0`, `last=3`, `hold_cnt=0`, state IDLE.
  - `last=3` makes requester 0 highest priority after reset.
  - `reset` overrides all other inputs.
  - Asserting `reset` mid-GRANT drops `gnt` at that edge with no GAP cycle and no `preempt`.
- Request-to-grant latency from IDLE: 1 cycle. `req` sampled at edge k gives `gnt` valid from edge k.
- Release-to-next-grant: 2 cycles.
  - Owner's `req` low at edge k: GAP from edge k.
  - New `gnt` from edge k+1 if another request is pending.
- Contended grant length: exactly `MAX_HOLD` cycles of `gnt` high, then one GAP cycle with `preempt=1`.
- Simultaneous release and hold-limit hit in the same cycle: treated as a release, `preempt=0`.
- Requests that appear or vanish during GAP are honoured as sampled at the GAP edge; a requester that drops before then is skipped.
- Wrap-around: the scan from `last+1` wraps 3 to 0. With `last=3`, the order is 0,1,2,3.

## Test plan
- Reset:
  - Stimulus: `reset=1` for 2 cycles with `req=4'b1111`.
  - Required: `gnt=0`, `sel=0`, `busy=0`, `preempt=0` during reset; `gnt=4'b0001`, `sel=0` on the first edge after reset deasserts.
- Sole requester, `MAX_HOLD=4`:
  - Stimulus: `req=4'b0100` for 20 cycles, then `req=0`.
  - Required: `gnt=4'b0100`, `sel=2` for all 20 cycles with no `preempt`; then one GAP cycle; then IDLE with `sel` still 2.
- Round robin with voluntary release:
  - Stimulus: `req=4'b1111`; each owner drops its bit after 3 grant cycles and re-raises it one cycle later.
  - Required: owner sequence 0,1,2,3,0, each 3 cycles, separated by single GAP cycles; `preempt` never set.
- Preemption, `MAX_HOLD=4`:
  - Stimulus: `req=4'b0011` held steady.
  - Required repeating pattern: `gnt=0001`×4, GAP with `preempt=1`, `gnt=0010`×4, GAP with `preempt=1`.
- Wrap and skip:
  - Stimulus 1: owner 3 releases while `req=4'b1001`.
    - Required: `gnt=0001` after the GAP.
  - Stimulus 2: `req=4'b1000` only, with contention.
    - Required: requester 3 is re-granted after each preempting GAP.
- Reset mid-grant:
  - Stimulus: pulse `reset` during requester 2's grant while `req=4'b0110`.
  - Required: `gnt=0` at that edge; `gnt=4'b0010` one cycle after reset deasserts, since priority restarts at 0.

Source files
------------

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: handshake bundle between four requesters and the arbiter.
//   req     : per-requester request, held high while that requester uses the path
//   gnt     : one-hot grant, zero when nobody owns the path
//   sel     : mux select, index of the current or most recent owner
//   busy    : high exactly while gnt is non-zero
//   preempt : one-cycle pulse in the gap that follows a hold-limit revocation
// master = requester side, slave = arbiter side.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    modport master (
        output req,
        input  gnt, sel, busy, preempt
    );

    modport slave (
        input  req,
        output gnt, sel, busy, preempt
    );
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: round-robin arbiter for a shared 4-input mux path.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : rr_arbiter4_if.slave (req in; gnt, sel, busy, preempt out)
// MAX_HOLD limits consecutive grant cycles while another requester waits
// (0 = unlimited). Every change of owner passes through one dead GAP cycle,
// so the mux select never switches owners on a single edge.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           reset,
    rr_arbiter4_if.slave   bus
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] last;
    logic [7:0] hold_cnt;

    logic [3:0] gnt_r;
    logic [1:0] sel_r;
    logic       busy_r;
    logic       preempt_r;

    // Circular scan starting just after the most recent owner, so that
    // owner ends up with the lowest priority.
    logic [1:0] win;
    logic       any_req;
    always_comb begin
        logic [1:0] idx;
        win     = 2'd0;
        any_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!any_req && bus.req[idx]) begin
                win     = idx;
                any_req = 1'b1;
            end
        end
    end

    // Someone other than the current owner is waiting.
    logic others_req;
    assign others_req = |(bus.req & ~(4'b0001 << sel_r));

    logic hold_hit;
    assign hold_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 2'd3;
            hold_cnt  <= 8'd0;
            gnt_r     <= 4'b0000;
            sel_r     <= 2'd0;
            busy_r    <= 1'b0;
            preempt_r <= 1'b0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    preempt_r <= 1'b0;
                    if (any_req) begin
                        state    <= GRANT;
                        gnt_r    <= 4'b0001 << win;
                        sel_r    <= win;
                        last     <= win;
                        hold_cnt <= 8'd1;
                        busy_r   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        gnt_r  <= 4'b0000;
                        busy_r <= 1'b0;
                    end
                end
                GRANT: begin
                    // Release takes precedence over a simultaneous limit hit.
                    if (!bus.req[sel_r]) begin
                        state     <= GAP;
                        gnt_r     <= 4'b0000;
                        busy_r    <= 1'b0;
                        preempt_r <= 1'b0;
                    end else if (hold_hit && others_req) begin
                        state     <= GAP;
                        gnt_r     <= 4'b0000;
                        busy_r    <= 1'b0;
                        preempt_r <= 1'b1;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_r     <= 4'b0000;
                    busy_r    <= 1'b0;
                    preempt_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.sel     = sel_r;
    assign bus.busy    = busy_r;
    assign bus.preempt = preempt_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed scenarios followed by random traffic, all checked
// against a cycle-level behavioural model of owner/priority rules.
module tb_rr_arbiter4;

    localparam int MH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rr_arbiter4_if ifc ();

    rr_arbiter4 #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: owner index (-1 = nobody), priority pointer, grant length.
    int m_owner;
    int m_last;
    int m_sel;
    int m_len;
    bit m_pre;

    task automatic model(input logic [3:0] r, input logic rst);
        if (rst) begin
            m_owner = -1; m_last = 3; m_sel = 0; m_len = 0; m_pre = 0;
        end else if (m_owner >= 0) begin
            m_pre = 0;
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (m_len == MH && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
                m_owner = -1;
                m_pre   = 1;
            end else begin
                m_len = (m_len < 255) ? m_len + 1 : 255;
            end
        end else begin
            m_pre = 0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c; m_sel = c; m_last = c; m_len = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_model();
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk("gnt",     ifc.gnt,            eg);
        chk("sel",     {2'b00, ifc.sel},   4'(m_sel));
        chk("busy",    {3'b000, ifc.busy}, {3'b000, m_owner >= 0});
        chk("preempt", {3'b000, ifc.preempt}, {3'b000, m_pre});
        chk("onehot0", {3'b000, $onehot0(ifc.gnt)}, 4'b0001);
        if (ifc.busy)
            chk("gnt_vs_sel", ifc.gnt, 4'b0001 << ifc.sel);
    endtask

    task automatic step(input logic [3:0] r, input logic rst);
        ifc.req = r;
        reset   = rst;
        @(posedge clk);
        #1;
        model(r, rst);
        check_model();
    endtask

    initial begin
        logic [3:0] r;
        int         dseq[$];
        logic       prev_busy;
        int         pos;

        ifc.req = 4'b0000;
        reset   = 1'b1;

        // Reset held with all requests asserted.
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        chk("rst_gnt",  ifc.gnt, 4'b0000);
        chk("rst_sel",  {2'b00, ifc.sel}, 4'd0);
        chk("rst_busy", {3'b000, ifc.busy}, 4'd0);
        chk("rst_pre",  {3'b000, ifc.preempt}, 4'd0);
        step(4'b1111, 1'b0);
        chk("post_rst_gnt", ifc.gnt, 4'b0001);
        chk("post_rst_sel", {2'b00, ifc.sel}, 4'd0);

        // Sole requester keeps the path far beyond the hold limit.
        step(4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(4'b0100, 1'b0);
            chk("sole_gnt", ifc.gnt, 4'b0100);
            chk("sole_pre", {3'b000, ifc.preempt}, 4'd0);
        end
        step(4'b0000, 1'b0);
        chk("sole_gap_busy", {3'b000, ifc.busy}, 4'd0);
        step(4'b0000, 1'b0);
        chk("sole_idle_sel", {2'b00, ifc.sel}, 4'd2);

        // Round robin with voluntary release after 3 grant cycles.
        step(4'b0000, 1'b1);
        prev_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_len == 3) r[m_owner] = 1'b0;
            step(r, 1'b0);
            if (ifc.busy && !prev_busy) dseq.push_back(int'(ifc.sel));
            chk("rr_pre", {3'b000, ifc.preempt}, 4'd0);
            prev_busy = ifc.busy;
        end
        chk("rr_count", 4'(dseq.size()), 4'd5);
        for (int i = 0; i < 5 && i < dseq.size(); i++)
            chk("rr_order", 4'(dseq[i]), 4'(i % 4));

        // Hold-limit preemption between two steady requesters.
        step(4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(4'b0011, 1'b0);
            pos = i % 10;
            if (pos < 4)       chk("pe_gnt0", ifc.gnt, 4'b0001);
            else if (pos == 4) chk("pe_gap0", {ifc.gnt[2:0], ifc.preempt}, 4'b0001);
            else if (pos < 9)  chk("pe_gnt1", ifc.gnt, 4'b0010);
            else               chk("pe_gap1", {ifc.gnt[2:0], ifc.preempt}, 4'b0001);
        end

        // Wrap: owner 3 releases, requester 0 wins after the gap.
        step(4'b0000, 1'b1);
        step(4'b1000, 1'b0);
        chk("wrap_own3", ifc.gnt, 4'b1000);
        step(4'b1001, 1'b0);
        step(4'b0001, 1'b0);
        chk("wrap_gap", ifc.gnt, 4'b0000);
        step(4'b1001, 1'b0);
        chk("wrap_gnt0", ifc.gnt, 4'b0001);

        // Skip: contender drops before the gap edge, owner 3 is re-granted.
        step(4'b0000, 1'b1);
        for (int i = 0; i < 24; i++) begin
            r = (m_owner >= 0) ? 4'b1100 : 4'b1000;
            step(r, 1'b0);
            if (ifc.busy) chk("skip_own3", ifc.gnt, 4'b1000);
        end

        // Reset during requester 2's grant.
        step(4'b0000, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b0110, 1'b0);
        chk("mid_own2", ifc.gnt, 4'b0100);
        step(4'b0110, 1'b1);
        chk("mid_rst_gnt", ifc.gnt, 4'b0000);
        chk("mid_rst_pre", {3'b000, ifc.preempt}, 4'd0);
        step(4'b0110, 1'b0);
        chk("mid_after_gnt", ifc.gnt, 4'b0010);

        // Random traffic: slowly toggling requests, occasional reset.
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            step(r, ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
